// File: rtl/chan_dispatch_pkg.sv
// Shared types for the channel dispatcher: FSM states, widths and
// the skid-buffer entry layout.
package chan_dispatch_pkg;

    localparam int CHAN_W = 7;
    localparam int DATA_W = 8;
    localparam int PORT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [PORT_W-1:0] dest;
    } h2f_ent_t;

endpackage

// File: rtl/chan_dispatch_skid2.sv
// Two-entry in-order FIFO for host-to-FPGA bytes; each entry carries
// its destination port. Flush empties it in one cycle.
module chan_skid2
    import chan_dispatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush_in,
    input  logic       push_in,
    input  h2f_ent_t   push_ent_in,
    input  logic       pop_in,
    output h2f_ent_t   head_out,
    output logic [PORT_W-1:0] tail_dest_out,
    output logic [1:0] count_out
);

    h2f_ent_t   ent0_q, ent0_d;
    h2f_ent_t   ent1_q, ent1_d;
    logic [1:0] count_q, count_d;
    logic       do_push;
    logic       do_pop;

    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        do_pop  = pop_in && (count_q != 2'd0);
        do_push = push_in && ((count_q != 2'd2) || do_pop);
        if (flush_in) begin
            count_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) ent0_d = push_ent_in;
                    else                 ent1_d = push_ent_in;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    ent0_d  = ent1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop: shift so the new byte lands last.
                    if (count_q == 2'd1) begin
                        ent0_d = push_ent_in;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = push_ent_in;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    assign head_out      = ent0_q;
    assign tail_dest_out = (count_q == 2'd2) ? ent1_q.dest : ent0_q.dest;
    assign count_out     = count_q;

endmodule

// File: rtl/chan_dispatch.sv
// Channel dispatcher: shares one host pipe among NUM_PORTS endpoints.
// Optional stall timeout enabled by CHAN_DISPATCH_TIMEOUT_EN.
module chan_dispatch
    import chan_dispatch_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int BASE_ADDR   = 0,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic [6:0]             chanAddr_in,
    input  logic [7:0]             h2fData_in,
    input  logic                   h2fValid_in,
    output logic                   h2fReady_out,
    output logic [7:0]             f2hData_out,
    output logic                   f2hValid_out,
    input  logic                   f2hReady_in,
    output logic [7:0]             pH2fData_out,
    output logic [NUM_PORTS-1:0]   pH2fValid_out,
    input  logic [NUM_PORTS-1:0]   pH2fReady_in,
    input  logic [8*NUM_PORTS-1:0] pF2hData_in,
    input  logic [NUM_PORTS-1:0]   pF2hValid_in,
    output logic [NUM_PORTS-1:0]   pF2hReady_out,
    output logic                   error_out
);

    localparam logic [CHAN_W-1:0] BASE = CHAN_W'(BASE_ADDR);
    localparam logic [CHAN_W-1:0] NPRT = CHAN_W'(NUM_PORTS);

    state_e            state_q, state_d;
    logic              live_q, live_d;
    logic [CHAN_W-1:0] sel;
    logic [PORT_W-1:0] sel_port;
    logic              in_range;
    logic              push;
    logic              pop;
    logic              flush;
    logic              head_valid;
    logic              mismatch;
    h2f_ent_t          head;
    h2f_ent_t          push_ent;
    logic [PORT_W-1:0] tail_dest;
    logic [1:0]        count;

    assign sel      = chanAddr_in - BASE;
    assign in_range = sel < NPRT;
    assign sel_port = sel[PORT_W-1:0];

    // live_q holds ready low for one cycle after reset and gates f2h.
    assign live_d       = 1'b1;
    assign head_valid   = count != 2'd0;
    assign h2fReady_out = live_q && (count != 2'd2) && (state_q != DRAIN);
    assign push         = h2fValid_in && h2fReady_out && in_range;
    assign push_ent     = '{data: h2fData_in, dest: sel_port};
    assign pH2fData_out = head.data;
    assign mismatch     = in_range && head_valid &&
                          ((head.dest != sel_port) || (tail_dest != sel_port));

    chan_skid2 u_skid (
        .clk           (clk_in),
        .rst           (reset_in),
        .flush_in      (flush),
        .push_in       (push),
        .push_ent_in   (push_ent),
        .pop_in        (pop),
        .head_out      (head),
        .tail_dest_out (tail_dest),
        .count_out     (count)
    );

    always_comb begin
        pH2fValid_out = '0;
        pop           = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (head_valid && (head.dest == PORT_W'(i))) begin
                pH2fValid_out[i] = 1'b1;
                pop              = pH2fReady_in[i];
            end
        end
    end

    always_comb begin
        f2hData_out   = '0;
        f2hValid_out  = 1'b0;
        pF2hReady_out = '0;
        if (live_q && (state_q != DRAIN)) begin
            if (in_range) begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (sel == CHAN_W'(i)) begin
                        f2hData_out      = pF2hData_in[8*i +: 8];
                        f2hValid_out     = pF2hValid_in[i];
                        pF2hReady_out[i] = f2hReady_in;
                    end
                end
            end else begin
                f2hValid_out = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (push) state_d = BUSY;
            end
            BUSY: begin
                if (flush)                                 state_d = IDLE;
                else if ((count == 2'd1) && pop && !push)  state_d = IDLE;
                else if (mismatch)                         state_d = DRAIN;
            end
            DRAIN: begin
                if (flush || (count == 2'd0) || ((count == 2'd1) && pop))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= live_d;
        end
    end

`ifdef CHAN_DISPATCH_TIMEOUT_EN
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        err_q, err_d;
    logic        stall;

    always_comb begin
        stall    = head_valid && !pop;
        flush    = stall && (to_cnt_q == 16'(TIMEOUT_CYC - 1));
        to_cnt_d = (!stall || flush) ? 16'd0 : to_cnt_q + 16'd1;
        err_d    = err_q | flush;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            to_cnt_q <= 16'd0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign error_out = err_q;
`else
    logic unused_timeout;

    assign flush          = 1'b0;
    assign error_out      = 1'b0;
    assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

endmodule
